// File: rtl/bus_seq_pkg.sv
// bus_seq_pkg: instruction-cycle phase encoding shared by the sequencer,
// the cpu and system benches, plus the cm_ram bank decode.
package bus_seq_pkg;

  typedef enum logic [3:0] {
    PH_A1   = 4'd0,
    PH_A2   = 4'd1,
    PH_A3   = 4'd2,
    PH_M1   = 4'd3,
    PH_M2   = 4'd4,
    PH_X1   = 4'd5,
    PH_X2   = 4'd6,
    PH_X3   = 4'd7,
    PH_WAIT = 4'd8
  } phase_t;

  localparam int PHASE_COUNT = 8;

  // Bank 0 owns line 0 alone; any other code appears on lines 3:1.
  function automatic logic [3:0] cm_ram_decode(
    input logic [2:0] bank
  );
    cm_ram_decode = (bank == 3'd0) ? 4'b0001
                                   : {bank, 1'b0};
  endfunction

endpackage

// File: rtl/bus_cycle_sequencer.sv
// bus_cycle_sequencer: 8-phase bus timing, drive enables, cm lines, DCL bank.
// Define BUS_SEQ_INSTR_COUNT_EN to build the instruction cycle counter.
module bus_cycle_sequencer
  import bus_seq_pkg::*;
#(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   hold,
  input  logic                   io_cmd,
  input  logic                   io_read,
  input  logic                   src,
  input  logic                   dcl_write,
  input  logic [2:0]             dcl_value,
  output logic [3:0]             phase,
  output logic                   sync,
  output logic                   cpu_drive,
  output logic                   rom_drive,
  output logic                   dev_drive,
  output logic                   cm_rom,
  output logic [3:0]             cm_ram,
  output logic [COUNT_WIDTH-1:0] instr_count
);

  phase_t     state_q, state_d;
  logic       io_read_q, io_read_d;
  logic       src_q, src_d;
  logic [2:0] bank_q, bank_d;
  logic       cm_act;

`ifdef BUS_SEQ_INSTR_COUNT_EN
  logic [COUNT_WIDTH-1:0] count_q, count_d;
`endif

  always_comb begin
    state_d   = state_q;
    io_read_d = io_read_q;
    src_d     = src_q;
    bank_d    = bank_q;
`ifdef BUS_SEQ_INSTR_COUNT_EN
    count_d   = count_q;
`endif
    unique case (state_q)
      PH_A1: state_d = PH_A2;
      PH_A2: state_d = PH_A3;
      PH_A3: state_d = PH_M1;
      PH_M1: state_d = PH_M2;
      PH_M2: begin
        state_d   = PH_X1;
        io_read_d = io_read;
        src_d     = src;
      end
      PH_X1: state_d = PH_X2;
      PH_X2: state_d = PH_X3;
      PH_X3: begin
        state_d   = hold ? PH_WAIT : PH_A1;
        io_read_d = 1'b0;
        src_d     = 1'b0;
        if (dcl_write) bank_d = dcl_value;
`ifdef BUS_SEQ_INSTR_COUNT_EN
        count_d = count_q + COUNT_WIDTH'(1);
`endif
      end
      PH_WAIT: state_d = hold ? PH_WAIT : PH_A1;
      default: state_d = PH_WAIT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= PH_WAIT;
      io_read_q <= 1'b0;
      src_q     <= 1'b0;
      bank_q    <= 3'd0;
`ifdef BUS_SEQ_INSTR_COUNT_EN
      count_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      io_read_q <= io_read_d;
      src_q     <= src_d;
      bank_q    <= bank_d;
`ifdef BUS_SEQ_INSTR_COUNT_EN
      count_q   <= count_d;
`endif
    end
  end

`ifdef BUS_SEQ_INSTR_COUNT_EN
  assign instr_count = count_q;
`else
  assign instr_count = '0;
`endif

  // Only the M2 command term looks at a live input (io_cmd).
  always_comb begin
    phase     = state_q;
    sync      = 1'b0;
    cpu_drive = 1'b0;
    rom_drive = 1'b0;
    dev_drive = 1'b0;
    cm_act    = 1'b0;
    unique case (state_q)
      PH_A1, PH_A2: cpu_drive = 1'b1;
      PH_A3: begin
        cpu_drive = 1'b1;
        cm_act    = 1'b1;
      end
      PH_M1: rom_drive = 1'b1;
      PH_M2: begin
        rom_drive = 1'b1;
        cm_act    = io_cmd;
      end
      PH_X1: ;
      PH_X2: begin
        cpu_drive = src_q;
        dev_drive = !src_q && io_read_q;
        cm_act    = src_q;
      end
      PH_X3: begin
        cpu_drive = src_q;
        sync      = !hold;
      end
      PH_WAIT: sync = !hold;
      default: ;
    endcase
    cm_rom = cm_act;
    cm_ram = cm_act ? cm_ram_decode(bank_q) : 4'b0000;
  end

endmodule

// File: tb/tb_bus_cycle_sequencer.sv
// tb_bus_cycle_sequencer: scripted and random stimulus against a
// cycle-position reference model of the bus sequencer.
module tb_bus_cycle_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        hold = 1'b0;
  logic        io_cmd = 1'b0;
  logic        io_read = 1'b0;
  logic        src = 1'b0;
  logic        dcl_write = 1'b0;
  logic [2:0]  dcl_value = 3'd0;
  logic [3:0]  phase;
  logic        sync, cpu_drive, rom_drive, dev_drive, cm_rom;
  logic [3:0]  cm_ram;
  logic [15:0] instr_count;

  int errors = 0;
  int checks = 0;

  bus_cycle_sequencer #(.COUNT_WIDTH(16)) dut (
    .clock(clock), .reset(reset), .hold(hold),
    .io_cmd(io_cmd), .io_read(io_read), .src(src),
    .dcl_write(dcl_write), .dcl_value(dcl_value),
    .phase(phase), .sync(sync), .cpu_drive(cpu_drive),
    .rom_drive(rom_drive), .dev_drive(dev_drive),
    .cm_rom(cm_rom), .cm_ram(cm_ram),
    .instr_count(instr_count)
  );

  always #5 clock = ~clock;

  logic [28:0] dut_vec;
  assign dut_vec = {phase, sync, cpu_drive, rom_drive,
                    dev_drive, cm_rom, cm_ram, instr_count};

  // Model: position in cycle (0..7 = A1..X3, 8 = WAIT)
  int          m_ph = 8;
  bit          m_src = 0;
  bit          m_ior = 0;
  int          m_bank = 0;
  logic [15:0] m_cnt = 16'd0;
  logic [3:0]  dec_tab [8];

  initial begin
    dec_tab[0] = 4'b0001; dec_tab[1] = 4'b0010;
    dec_tab[2] = 4'b0100; dec_tab[3] = 4'b0110;
    dec_tab[4] = 4'b1000; dec_tab[5] = 4'b1010;
    dec_tab[6] = 4'b1100; dec_tab[7] = 4'b1110;
  end

  function automatic logic [28:0] exp_vec();
    logic s, c, r, d, act;
    logic [15:0] cnt;
    s   = (m_ph == 7 || m_ph == 8) && !hold;
    c   = (m_ph <= 2) || ((m_ph == 6 || m_ph == 7) && m_src);
    r   = (m_ph == 3 || m_ph == 4);
    d   = (m_ph == 6) && !m_src && m_ior;
    act = (m_ph == 2) || (m_ph == 4 && io_cmd)
       || (m_ph == 6 && m_src);
`ifdef BUS_SEQ_INSTR_COUNT_EN
    cnt = m_cnt;
`else
    cnt = 16'd0;
`endif
    return {4'(m_ph), s, c, r, d, act,
            act ? dec_tab[m_bank] : 4'b0000, cnt};
  endfunction

  task automatic model_step();
    if (reset) begin
      m_ph = 8; m_src = 0; m_ior = 0; m_bank = 0; m_cnt = 16'd0;
    end else if (m_ph == 4) begin
      m_src = src; m_ior = io_read; m_ph = 5;
    end else if (m_ph == 7) begin
      if (dcl_write) m_bank = int'(dcl_value);
      m_src = 0; m_ior = 0;
      m_cnt = m_cnt + 16'd1;
      m_ph = hold ? 8 : 0;
    end else if (m_ph == 8) begin
      m_ph = hold ? 8 : 0;
    end else begin
      m_ph = m_ph + 1;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic clear_inputs();
    reset = 0; hold = 0; io_cmd = 0; io_read = 0;
    src = 0; dcl_write = 0; dcl_value = 3'd0;
  endtask

  task automatic to_phase(input int p);
    int k;
    k = 0;
    while (m_ph != p && k < 20) begin
      tick();
      k++;
    end
    checks++;
    if (m_ph != p) begin
      errors++;
      $display("FAIL to_phase timeout want=%0d at=%0d", p, m_ph);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL reset_seq cyc=%0d got=%h exp=%h",
                 i, dut_vec, exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_hold();
    clear_inputs();
    to_phase(7);
    for (int i = 0; i < 14; i++) begin
      hold = (i < 3);
      @(negedge clock);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL hold cyc=%0d got=%h exp=%h",
                 i, dut_vec, exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_src();
    clear_inputs();
    to_phase(4);
    for (int i = 0; i < 14; i++) begin
      src = (i == 0);
      @(negedge clock);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL src cyc=%0d got=%h exp=%h",
                 i, dut_vec, exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_io_read();
    clear_inputs();
    to_phase(7);
    dcl_write = 1;
    dcl_value = 3'b101;
    tick();
    clear_inputs();
    to_phase(4);
    for (int i = 0; i < 12; i++) begin
      io_read = (i == 0);
      io_cmd  = (i == 0);
      @(negedge clock);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL io_read cyc=%0d got=%h exp=%h",
                 i, dut_vec, exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_dcl();
    clear_inputs();
    to_phase(0);
    for (int i = 0; i < 26; i++) begin
      dcl_write = (i < 8) || (i == 13);
      dcl_value = (i < 8) ? 3'b110 : 3'b001;
      @(negedge clock);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL dcl cyc=%0d got=%h exp=%h",
                 i, dut_vec, exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    to_phase(4);
    for (int i = 0; i < 16; i++) begin
      src   = (i == 0);
      reset = (i == 1);
      @(negedge clock);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL reset_mid cyc=%0d got=%h exp=%h",
                 i, dut_vec, exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      reset     = ($urandom_range(0, 59) == 0);
      hold      = ($urandom_range(0, 3) == 0);
      io_cmd    = 1'($urandom_range(0, 1));
      io_read   = 1'($urandom_range(0, 1));
      src       = ($urandom_range(0, 2) == 0);
      dcl_write = ($urandom_range(0, 3) == 0);
      dcl_value = 3'($urandom_range(0, 7));
      @(negedge clock);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL random cyc=%0d got=%h exp=%h",
                 i, dut_vec, exp_vec());
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_hold();
    test_src();
    test_io_read();
    test_dcl();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
